cp0_regfile: RTL and testbench

Coprocessor-0 register file: the responder for the exception/return control the writeback stage issues (EXLClr on eret, mfc0 reads, mtc0 writes). It holds SR, Cause, EPC, PRId and a Count/Compare timer. It arbitrates interrupts and exceptions, captures the victim PC, and raises Take so the pipeline flushes and redirects. It sits beside the main register file and is written and read from the W-stage.

---
 rtl/cp0_pkg.sv | 43 ++++
 rtl/cp0_timer.sv | 51 +++++
 rtl/cp0_regfile.sv | 145 ++++++++++++++
 tb/tb_cp0_regfile.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, SR/Cause field positions,
// exception codes and the victim-PC helper.
package cp0_pkg;

    // CP0 register addresses (mfc0/mtc0 rd field)
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // SR field positions
    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned SR_IM_LO = 10;
    localparam int unsigned SR_IM_HI = 15;

    // Cause field positions
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    // Exception codes written to Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Restart PC: a delay-slot victim restarts at its branch; word aligned
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] raw;
        raw = bd ? (pc - 32'd4) : pc;
        return raw & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer. Count free-runs and wraps; TI latches one cycle
// after Count equals Compare and is cleared by any write to Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    // Next-state: load or increment Count, load Compare, set/clear TI
    always_comb begin
        count_d   = wr_count ? din : (count_q + 32'd1);
        compare_d = wr_compare ? din : compare_q;
        ti_d      = ti_q;
        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
        // the acknowledge write wins over a coincident match
        if (wr_compare) begin
            ti_d = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '1;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: SR, Cause, EPC, PRId plus Count/Compare.
// Arbitrates interrupts against synchronous exceptions, captures the
// victim PC and raises Take for the pipeline to flush and redirect.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0001_8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic        ExcValid,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPC,
    output logic        Take,
    output logic        EXL
);

    // SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields (TI lives in the timer)
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    // EPC
    logic [31:0] epc_q, epc_d;

    logic        int_pend;
    logic        take;
    logic        mtc0_en;
    logic        wr_count;
    logic        wr_compare;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .din        (DIn),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Interrupt/exception arbitration; a Take squashes the same-cycle mtc0
    always_comb begin
        int_pend   = ie_q & ~exl_q & (|(ip_q & im_q));
        take       = ~reset & (int_pend | (ExcValid & ~exl_q));
        mtc0_en    = WE & ~take;
        wr_count   = mtc0_en && (A2 == CP0_COUNT);
        wr_compare = mtc0_en && (A2 == CP0_COMPARE);
    end

    // Next-state for SR/Cause/EPC: Take > mtc0 write > EXLClr
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        // IP samples the lines every cycle; the timer rides on line 5
        ip_d  = HWInt | {ti, 5'b0_0000};
        if (take) begin
            exl_d = 1'b1;
            bd_d  = BD;
            epc_d = victim_epc(PC, BD);
            exc_d = int_pend ? EXC_INT : ExcCode;
        end else if (WE) begin
            case (A2)
                CP0_SR: begin
                    im_d  = DIn[SR_IM_HI:SR_IM_LO];
                    exl_d = DIn[SR_EXL];
                    ie_d  = DIn[SR_IE];
                end
                CP0_EPC: epc_d = DIn & ~32'h0000_0003;
                default: ;
            endcase
        end else if (EXLClr) begin
            exl_d = 1'b0;
        end
    end

    // SR/Cause/EPC state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    // mfc0 read port: combinational from current state, no write bypass
    always_comb begin
        DOut = '0;
        case (A1)
            CP0_COUNT:   DOut = count;
            CP0_COMPARE: DOut = compare;
            CP0_SR: begin
                DOut[SR_IM_HI:SR_IM_LO] = im_q;
                DOut[SR_EXL]            = exl_q;
                DOut[SR_IE]             = ie_q;
            end
            CP0_CAUSE: begin
                DOut[CAUSE_BD]                    = bd_q;
                DOut[CAUSE_TI]                    = ti;
                DOut[CAUSE_IP_HI:CAUSE_IP_LO]     = ip_q;
                DOut[CAUSE_EXC_HI:CAUSE_EXC_LO]   = exc_q;
            end
            CP0_EPC:     DOut = epc_q;
            CP0_PRID:    DOut = PRID;
            default:     DOut = '0;
        endcase
    end

    assign EPC  = epc_q;
    assign Take = take;
    assign EXL  = exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios with literal
// expectations, then randomized traffic against a word-level model.
module tb_cp0_regfile;

    localparam logic [31:0] PRID_V = 32'h0001_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic        ExcValid;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut, EPC;
    logic        Take, EXL;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    cp0_regfile #(.PRID(PRID_V)) dut (
        .clk      (clk),
        .reset    (reset),
        .A1       (A1),
        .A2       (A2),
        .DIn      (DIn),
        .WE       (WE),
        .PC       (PC),
        .BD       (BD),
        .ExcValid (ExcValid),
        .ExcCode  (ExcCode),
        .HWInt    (HWInt),
        .EXLClr   (EXLClr),
        .DOut     (DOut),
        .EPC      (EPC),
        .Take     (Take),
        .EXL      (EXL)
    );

    // ---------------- reference model (architectural register words) ----------------
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;

    task automatic model_reset();
        m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
    endtask

    function automatic logic m_intpend();
        logic [31:0] im, ip;
        im = (m_sr >> 10) & 32'h3F;
        ip = (m_cause >> 10) & 32'h3F;
        return m_sr[0] && !m_sr[1] && ((im & ip) != 0);
    endfunction

    function automatic logic m_take();
        return !reset && (m_intpend() || (ExcValid && !m_sr[1]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic        t, ip_pend, wr, old_ti, new_ti, bd_f;
        logic [4:0]  exc_f;
        logic [5:0]  new_ip;
        if (reset) begin
            model_reset();
            return;
        end
        t       = m_take();
        ip_pend = m_intpend();
        wr      = WE && !t;
        old_ti  = m_cause[30];
        if (wr && A2 == 5'd11)            new_ti = 1'b0;
        else if (m_count == m_compare)    new_ti = 1'b1;
        else                              new_ti = old_ti;
        new_ip  = HWInt | (old_ti ? 6'd32 : 6'd0);
        m_count = (wr && A2 == 5'd9) ? DIn : m_count + 1;
        if (wr && A2 == 5'd11) m_compare = DIn;
        bd_f  = m_cause[31];
        exc_f = m_cause[6:2];
        if (t) begin
            m_sr  = m_sr | 32'h2;
            bd_f  = BD;
            m_epc = (BD ? PC - 4 : PC) & 32'hFFFF_FFFC;
            exc_f = ip_pend ? 5'd0 : ExcCode;
        end else if (WE) begin
            if (A2 == 5'd12) m_sr  = DIn & 32'h0000_FC03;
            if (A2 == 5'd14) m_epc = DIn & 32'hFFFF_FFFC;
        end else if (EXLClr) begin
            m_sr = m_sr & ~32'h2;
        end
        m_cause = {bd_f, new_ti, 14'd0, new_ip, 3'd0, exc_f, 2'd0};
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs set: compare all outputs, then advance one clock
    task automatic tick();
        #1;
        chk("Take", {31'd0, Take}, {31'd0, m_take()});
        chk("EXL",  {31'd0, EXL},  {31'd0, m_sr[1]});
        chk("EPC",  EPC, m_epc);
        chk("DOut", DOut, m_read(A1));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; WE = 0; A2 = 0; DIn = 0; PC = 0; BD = 0;
        ExcValid = 0; ExcCode = 0; HWInt = 0; EXLClr = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        WE = 1; A2 = a; DIn = d;
        tick();
        WE = 0;
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 6))
            0: return 5'd9;
            1: return 5'd11;
            2: return 5'd12;
            3: return 5'd13;
            4: return 5'd14;
            5: return 5'd15;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] v;
        idle();
        A1 = 5'd12;
        reset = 1;
        @(posedge clk); @(posedge clk);
        model_reset();
        @(negedge clk);

        // Take must stay low during reset even with causes present
        reset = 1; ExcValid = 1; HWInt = 6'h3F;
        #1 chk("take_in_reset", {31'd0, Take}, 32'd0);
        tick();
        idle();

        // Reset values
        A1 = 5'd12; #1 chk("rst_sr", DOut, 32'h0);
        A1 = 5'd13; #1 chk("rst_cause", DOut, 32'h0);
        A1 = 5'd14; #1 chk("rst_epc", DOut, 32'h0);
        A1 = 5'd15; #1 chk("rst_prid", DOut, PRID_V);
        A1 = 5'd11; #1 chk("rst_compare", DOut, 32'hFFFF_FFFF);
        chk("rst_exl", {31'd0, EXL}, 32'd0);
        tick();

        // Interrupt via HWInt[2], one cycle through IP
        mtc0(5'd12, 32'h0000_FC01);
        HWInt = 6'b000100; PC = 32'h0000_1000;
        #1 chk("hwint_no_take_yet", {31'd0, Take}, 32'd0);
        tick();
        #1 chk("hwint_take", {31'd0, Take}, 32'd1);
        tick();
        A1 = 5'd13; HWInt = 6'b001000;
        #1 v = DOut;
        chk("int_exccode", (v >> 2) & 32'h1F, 32'd0);
        chk("int_epc", EPC, 32'h0000_1000);
        chk("int_exl", {31'd0, EXL}, 32'd1);
        tick();
        #1 chk("masked_by_exl", {31'd0, Take}, 32'd0);
        tick();
        EXLClr = 1; tick(); EXLClr = 0;
        #1 chk("eret_exl_clear", {31'd0, EXL}, 32'd0);
        chk("int_after_eret", {31'd0, Take}, 32'd1);
        tick();
        HWInt = 0; tick();
        EXLClr = 1; tick(); EXLClr = 0;

        // Delay-slot exception: EPC = PC-4, Cause = BD | ExcCode 12
        ExcValid = 1; ExcCode = 5'd12; BD = 1; PC = 32'h0000_3010;
        #1 chk("exc_take", {31'd0, Take}, 32'd1);
        tick();
        A1 = 5'd13;
        #1 chk("exc_cause", DOut, 32'h8000_0030);
        chk("exc_held_one_take", {31'd0, Take}, 32'd0);
        A1 = 5'd14;
        #1 chk("exc_epc_rd", DOut, 32'h0000_300C);
        chk("exc_epc_port", EPC, 32'h0000_300C);
        tick();
        ExcValid = 0; BD = 0;

        // Interrupt beats exception; same-cycle mtc0 EPC is dropped
        EXLClr = 1; HWInt = 6'b000001; tick(); EXLClr = 0;
        ExcValid = 1; ExcCode = 5'd4; PC = 32'h0000_4444;
        WE = 1; A2 = 5'd14; DIn = 32'hDEAD_BEEF;
        #1 chk("combo_take", {31'd0, Take}, 32'd1);
        tick();
        WE = 0; ExcValid = 0; HWInt = 0; A1 = 5'd13;
        #1 v = DOut;
        chk("combo_exccode", (v >> 2) & 32'h1F, 32'd0);
        chk("combo_epc", EPC, 32'h0000_4444);
        tick();

        // EXLClr with Take: EXL stays set; EXLClr alone clears it
        EXLClr = 1; tick();
        ExcValid = 1; EXLClr = 1;
        #1 chk("clr_vs_take", {31'd0, Take}, 32'd1);
        tick();
        ExcValid = 0; EXLClr = 0;
        #1 chk("exl_kept", {31'd0, EXL}, 32'd1);
        EXLClr = 1; tick(); EXLClr = 0;
        #1 chk("exl_cleared", {31'd0, EXL}, 32'd0);

        // Timer interrupt on line 5
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        A1 = 5'd9;
        #1 chk("count_loaded", DOut, 32'd0);
        tick();
        repeat (4) tick();
        A1 = 5'd13;
        #1 v = DOut;
        chk("ti_not_yet", {31'd0, v[30]}, 32'd0);
        tick();
        #1 v = DOut;
        chk("ti_set", {31'd0, v[30]}, 32'd1);
        chk("ti_take_not_yet", {31'd0, Take}, 32'd0);
        tick();
        #1 chk("timer_take", {31'd0, Take}, 32'd1);
        tick();
        mtc0(5'd11, 32'h0000_0100);
        A1 = 5'd13;
        #1 v = DOut;
        chk("ti_cleared", {31'd0, v[30]}, 32'd0);
        tick();
        mtc0(5'd9, 32'hFFFF_FFFF);
        A1 = 5'd9;
        #1 chk("count_max", DOut, 32'hFFFF_FFFF);
        tick();
        #1 chk("count_wrap", DOut, 32'd0);
        tick();

        // Randomized traffic against the model
        for (int unsigned i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            A1       = pick_addr();
            WE       = ($urandom_range(0, 3) == 0);
            A2       = pick_addr();
            if (A2 == 5'd11 && $urandom_range(0, 1) == 0)
                DIn = m_count + $urandom_range(1, 8);
            else if (A2 == 5'd12)
                DIn = $urandom | 32'h1;
            else
                DIn = $urandom;
            EXLClr   = !WE && ($urandom_range(0, 5) == 0);
            ExcValid = ($urandom_range(0, 5) == 0);
            ExcCode  = 5'($urandom);
            PC       = $urandom;
            BD       = 1'($urandom);
            HWInt    = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
